// File: rtl/word_asm_pkg.sv
// Shared definitions for the byte-to-word assembler path: state encoding,
// lane index width and default sizing of the sequencer.
package word_asm_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int LANE_W             = 3;
    localparam int DEF_BYTES_PER_WORD = 8;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        FILL = S_FILL,
        HOLD = S_HOLD
    } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: one-cycle pulse when d goes from 0 to 1.
// RESET_VAL=1 keeps a level that is already high through reset from counting as an edge.
module rise_edge_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/byte_word_seq_ctrl.sv
// Sequencer that steers received bytes into the lanes of the word assembler,
// presents the finished word with a valid/ready handshake and flags timeouts/overruns.
module byte_word_seq_ctrl
    import word_asm_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              lane_we,
    output logic [LANE_W-1:0] lane_sel,
    output logic [7:0]        lane_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              overrun_err,
    output logic              timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t              state, state_n;
    logic [LANE_W-1:0]   lane_cnt, lane_cnt_n;
    logic [TMR_W-1:0]    gap_tmr, gap_tmr_n;
    logic                rx_edge;
    logic                handshake;
    logic                lane_we_n, word_valid_n, busy_n, overrun_n, timeout_n;
    logic [LANE_W-1:0]   lane_sel_n;
    logic [7:0]          lane_data_n;

    rise_edge_det #(
        .RESET_VAL(1'b1)
    ) u_rx_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_done),
        .pulse(rx_edge)
    );

    // The consumer only sees the word once word_valid is up, so ready counts from then on.
    assign handshake = (state == HOLD) && word_valid && word_ready;

    always_comb begin
        state_n     = state;
        lane_cnt_n  = lane_cnt;
        gap_tmr_n   = gap_tmr;
        lane_we_n   = 1'b0;
        lane_sel_n  = lane_sel;
        lane_data_n = lane_data;
        overrun_n   = 1'b0;
        timeout_n   = 1'b0;

        case (state)
            IDLE: begin
                lane_cnt_n = '0;
                gap_tmr_n  = '0;
                if (rx_edge) begin
                    lane_we_n   = 1'b1;
                    lane_sel_n  = '0;
                    lane_data_n = rx_data;
                    lane_cnt_n  = LANE_W'(1);
                    state_n     = FILL;
                end
            end
            FILL: begin
                if (rx_edge) begin
                    lane_we_n   = 1'b1;
                    lane_sel_n  = lane_cnt;
                    lane_data_n = rx_data;
                    gap_tmr_n   = '0;
                    if (lane_cnt == LAST_LANE) begin
                        lane_cnt_n = '0;
                        state_n    = HOLD;
                    end else begin
                        lane_cnt_n = lane_cnt + 1'b1;
                    end
                end else if (gap_tmr == TMR_LAST) begin
                    timeout_n  = 1'b1;
                    lane_cnt_n = '0;
                    gap_tmr_n  = '0;
                    state_n    = IDLE;
                end else begin
                    gap_tmr_n = gap_tmr + 1'b1;
                end
            end
            HOLD: begin
                // A byte arriving with the accepting ready lands in lane 0 after the word is taken.
                if (handshake) begin
                    if (rx_edge) begin
                        lane_we_n   = 1'b1;
                        lane_sel_n  = '0;
                        lane_data_n = rx_data;
                        lane_cnt_n  = LANE_W'(1);
                        gap_tmr_n   = '0;
                        state_n     = FILL;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (rx_edge) begin
                    overrun_n = 1'b1;
                end
            end
            default: begin
                state_n    = IDLE;
                lane_cnt_n = '0;
                gap_tmr_n  = '0;
            end
        endcase

        word_valid_n = (state == HOLD) && (state_n == HOLD);
        busy_n       = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            lane_cnt    <= '0;
            gap_tmr     <= '0;
            lane_we     <= 1'b0;
            lane_sel    <= '0;
            lane_data   <= 8'h00;
            word_valid  <= 1'b0;
            busy        <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            lane_cnt    <= lane_cnt_n;
            gap_tmr     <= gap_tmr_n;
            lane_we     <= lane_we_n;
            lane_sel    <= lane_sel_n;
            lane_data   <= lane_data_n;
            word_valid  <= word_valid_n;
            busy        <= busy_n;
            overrun_err <= overrun_n;
            timeout_err <= timeout_n;
        end
    end

endmodule

// File: tb/tb_byte_word_seq_ctrl.sv
// Self-checking bench for byte_word_seq_ctrl: table-driven full word plus
// hand-written handshake, timeout, race, overrun and reset sequences.
module tb_byte_word_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        word_ready;
    logic        lane_we;
    logic [2:0]  lane_sel;
    logic [7:0]  lane_data;
    logic        word_valid;
    logic        busy;
    logic        overrun_err;
    logic        timeout_err;
    logic [63:0] asm_word;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       exp_we;
        logic [2:0] exp_sel;
        logic       exp_ovr;
        logic       exp_wv_strobe;
        logic       exp_wv_next;
    } vec_t;

    vec_t full_word[8];

    byte_word_seq_ctrl #(
        .BYTES_PER_WORD(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .lane_we    (lane_we),
        .lane_sel   (lane_sel),
        .lane_data  (lane_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overrun_err(overrun_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural assembler: captures each lane write at the end of the strobe cycle.
    always @(posedge clk) begin
        if (lane_we) asm_word[lane_sel*8 +: 8] <= lane_data;
    end

    function automatic vec_t mk(input logic [7:0] d, input logic r, input logic we,
                                input logic [2:0] sel, input logic ovr,
                                input logic wv_s, input logic wv_n);
        vec_t v;
        v.data = d; v.rdy = r; v.exp_we = we; v.exp_sel = sel;
        v.exp_ovr = ovr; v.exp_wv_strobe = wv_s; v.exp_wv_next = wv_n;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic [7:0] d, input logic rdy);
        rx_done    = rd;
        rx_data    = d;
        word_ready = rdy;
    endtask

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string nm);
        checkOutput({nm, ".lane_we"},     64'(lane_we),     64'd0);
        checkOutput({nm, ".lane_sel"},    64'(lane_sel),    64'd0);
        checkOutput({nm, ".lane_data"},   64'(lane_data),   64'd0);
        checkOutput({nm, ".word_valid"},  64'(word_valid),  64'd0);
        checkOutput({nm, ".busy"},        64'(busy),        64'd0);
        checkOutput({nm, ".overrun_err"}, 64'(overrun_err), 64'd0);
        checkOutput({nm, ".timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    // One byte: rx_done high for one cycle, then low for three (4-cycle spacing).
    task automatic doByte(input vec_t v, input string nm);
        applyStimulus(1'b1, v.data, v.rdy);
        tick();
        applyStimulus(1'b0, v.data, 1'b0);
        @(negedge clk);
        checkOutput({nm, ".lane_we"}, 64'(lane_we), 64'(v.exp_we));
        if (v.exp_we) begin
            checkOutput({nm, ".lane_sel"},  64'(lane_sel),  64'(v.exp_sel));
            checkOutput({nm, ".lane_data"}, 64'(lane_data), 64'(v.data));
        end
        checkOutput({nm, ".overrun"},    64'(overrun_err), 64'(v.exp_ovr));
        checkOutput({nm, ".timeout"},    64'(timeout_err), 64'd0);
        checkOutput({nm, ".busy"},       64'(busy),        64'd1);
        checkOutput({nm, ".wv_strobe"},  64'(word_valid),  64'(v.exp_wv_strobe));
        tick();
        @(negedge clk);
        checkOutput({nm, ".we_drop"},    64'(lane_we),     64'd0);
        checkOutput({nm, ".ovr_drop"},   64'(overrun_err), 64'd0);
        checkOutput({nm, ".wv_next"},    64'(word_valid),  64'(v.exp_wv_next));
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            full_word[i] = mk(8'((i + 1) * 17), 1'b0, 1'b1, 3'(i), 1'b0, 1'b0, (i == 7));
        end

        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) begin
            doByte(full_word[i], $sformatf("full.lane%0d", i));
        end
        tick();
        @(negedge clk);
        checkOutput("full.held_valid", 64'(word_valid), 64'd1);
        checkOutput("full.held_busy",  64'(busy),       64'd1);
        checkOutput("full.asm_word",   asm_word,        64'h8877665544332211);

        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("hs.word_valid", 64'(word_valid), 64'd0);
        checkOutput("hs.busy",       64'(busy),       64'd0);

        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("idle_ready.word_valid", 64'(word_valid), 64'd0);
        checkOutput("idle_ready.busy",       64'(busy),       64'd0);

        doByte(mk(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), "to.lane0");
        doByte(mk(8'h02, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0), "to.lane1");
        doByte(mk(8'h03, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "to.lane2");
        repeat (12) tick();
        @(negedge clk);
        checkOutput("to.early_timeout", 64'(timeout_err), 64'd0);
        checkOutput("to.early_busy",    64'(busy),        64'd1);
        tick();
        @(negedge clk);
        checkOutput("to.pulse",   64'(timeout_err), 64'd1);
        checkOutput("to.busy",    64'(busy),        64'd0);
        checkOutput("to.lane_we", 64'(lane_we),     64'd0);
        tick();
        @(negedge clk);
        checkOutput("to.pulse_end", 64'(timeout_err), 64'd0);
        tick();
        doByte(mk(8'hA5, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), "to.restart");
        checkOutput("to.asm_lane0", 64'(asm_word[7:0]), 64'hA5);

        doByte(mk(8'hB1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0), "race.lane1");
        doByte(mk(8'hB2, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "race.lane2");
        repeat (12) tick();
        doByte(mk(8'hC3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0), "race.lane3");
        doByte(mk(8'hB4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0), "race.lane4");
        doByte(mk(8'hB5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0), "race.lane5");
        doByte(mk(8'hB6, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0), "race.lane6");
        doByte(mk(8'hB7, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1), "race.lane7");
        checkOutput("race.asm_word", asm_word, 64'hB7B6B5B4C3B2B1A5);

        doByte(mk(8'h5A, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1), "ovr.drop");
        checkOutput("ovr.asm_word", asm_word, 64'hB7B6B5B4C3B2B1A5);
        doByte(mk(8'h3C, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), "ovr.simul");
        checkOutput("ovr.asm_lane0", 64'(asm_word[7:0]), 64'h3C);

        doByte(mk(8'hD1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0), "rst.lane1");
        doByte(mk(8'hD2, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0), "rst.lane2");
        doByte(mk(8'hD3, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0), "rst.lane3");
        doByte(mk(8'hD4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0), "rst.lane4");
        applyStimulus(1'b1, 8'hEE, 1'b0);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checkResetOutputs("rst.mid");
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("rst.no_we1",  64'(lane_we), 64'd0);
        checkOutput("rst.busy1",   64'(busy),    64'd0);
        tick();
        @(negedge clk);
        checkOutput("rst.no_we2",  64'(lane_we), 64'd0);
        checkOutput("rst.busy2",   64'(busy),    64'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        doByte(mk(8'h77, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0), "rst.new_lane0");
        doByte(mk(8'h78, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0), "rst.new_lane1");
        checkOutput("rst.asm_low", 64'(asm_word[15:0]), 64'h7877);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/byte_word_seq_ctrl.md
# byte_word_seq_ctrl

Sequencer for the byte-to-64-bit word assembler.
- Detects each completed byte from the UART receiver and issues one lane-write strobe per byte with its lane index, steering 8 bytes into the assembler's 64-bit register.
- Raises a valid/ready handshake once all lanes are written.
- Aborts partial words on an inter-byte timeout and drops bytes that arrive while a finished word is still unconsumed.
- Sits between the UART rx and the assembler/word consumer.

## Interface
Parameters:
- BYTES_PER_WORD, 8: lanes per word; legal range 2..8; lane_sel width fixed at 3.
- TIMEOUT_CYCLES, 50000: maximum idle cycles between bytes of one word; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx_done  in  1  receiver byte-complete flag (level or pulse); rising edge = one new byte.
- rx_data  in  8  received byte, stable while rx_done is high.
- lane_we  out  1  one-cycle write strobe to the assembler.
- lane_sel  out  3  lane index for lane_we; lane k = bits [8k+7:8k].
- lane_data  out  8  byte to write, registered copy of rx_data.
- word_valid  out  1  assembled word complete; held until accepted.
- word_ready  in  1  consumer accepts the word.
- busy  out  1  high in FILL or HOLD.
- overrun_err  out  1  one-cycle pulse: byte dropped.
- timeout_err  out  1  one-cycle pulse: partial word aborted.

## Operation
Edge detect:
- Register rx_q samples rx_done each cycle.
- rx_q reset value is 1, so rx_done held high through reset is not an edge.
- An edge is rx_done & ~rx_q.

States:
- IDLE
  - lane_cnt = 0, gap timer = 0.
  - On an edge: write lane 0, set lane_cnt = 1, go to FILL.
- FILL
  - On an edge: write lane lane_cnt, increment lane_cnt, clear the gap timer.
  - If the written lane is BYTES_PER_WORD-1: go to HOLD, lane_cnt = 0.
  - With no edge: gap timer increments.
  - When the timer reaches TIMEOUT_CYCLES-1 with no edge that cycle: pulse timeout_err, set lane_cnt = 0, go to IDLE.
  - The assembler is not cleared on timeout; the next word overwrites it.
- HOLD
  - word_valid = 1.
  - When word_ready is sampled high: word_valid drops the next cycle and the state goes to IDLE.
  - An edge with word_ready low: byte dropped, overrun_err pulses, state unchanged.
  - An edge with word_ready high in the same cycle: handshake completes and the byte is accepted as lane 0, going to FILL with no overrun. This is safe because the consumer samples the word at that edge and the lane-0 write lands one cycle later.

Boundary rules:
- An edge in the same cycle the timer hits terminal count wins: byte accepted, no timeout.
- word_ready while not in HOLD is ignored.
- Reset mid-word:
  - Outputs return to reset values and the state goes to IDLE.
  - Partial lanes are abandoned; no error pulse.

## Timing
- All outputs are registered.
- Reset values: lane_we 0, lane_sel 0, lane_data 0x00, word_valid 0, busy 0, overrun_err 0, timeout_err 0.
- Edge detected in cycle t (rx_done=1 at t, 0 at t-1): lane_we, lane_sel and lane_data are valid in cycle t+1 only. The assembler captures at the end of t+1.
- Last-lane strobe in cycle t+1: word_valid rises in t+2, so the assembler output is complete.
- Throughput limit: one byte per 2 cycles; rx_done must be low for at least 1 cycle between bytes.
- Timeout:
  - timeout_err is high in the cycle after the TIMEOUT_CYCLES-th consecutive edge-free FILL cycle.
  - Count starts after the cycle of the last accepted edge.
- overrun_err is high in cycle t+1 for an edge dropped in cycle t.
- busy:
  - Rises with the first lane_we.
  - Falls the cycle after handshake (or after timeout_err).
  - Stays high across a HOLD→FILL back-to-back transition.

## Structure
- Shared package word_asm_pkg holds:
  - State encoding localparams: S_IDLE=2'd0, S_FILL=2'd1, S_HOLD=2'd2.
  - LANE_W=3.
  - Default BYTES_PER_WORD and TIMEOUT_CYCLES.
- Gap timer width: $clog2(TIMEOUT_CYCLES), local.
- One natural sub-module, rise_edge_det:
  - Ports: clk, rst_n, d → pulse.
  - Parameter: reset value of the delay flop.
  - Reusable by the receiver path.

## Test plan
Bench uses TIMEOUT_CYCLES=16 and BYTES_PER_WORD=8; a behavioural assembler checks lane writes.
- Full word:
  - Stimulus: 8 rx_done pulses 4 cycles apart, bytes 0x11..0x88; word_ready held low.
  - Response: lane_sel 0..7 with matching lane_data; word_valid rises 1 cycle after the lane-7 strobe; assembled word 0x8877665544332211; stays valid.
- Handshake:
  - Stimulus: assert word_ready 3 cycles after word_valid.
  - Response: word_valid and busy low the next cycle; state IDLE.
- Timeout:
  - Stimulus: 3 bytes, then 16 idle cycles.
  - Response: one timeout_err pulse; the next byte 0xA5 is written to lane 0, not lane 3.
- Timeout race:
  - Stimulus: an edge exactly on the terminal timer cycle.
  - Response: byte accepted as lane 3; no timeout_err.
- Overrun vs simultaneous:
  - Stimulus 1: in HOLD, byte 0x5A with word_ready low.
  - Response 1: overrun_err pulse, no lane_we.
  - Stimulus 2: byte 0x3C with word_ready high in the same cycle.
  - Response 2: handshake completes, lane 0 = 0x3C, busy stays 1, no overrun_err.
- Reset:
  - Stimulus: rst_n low for 1 cycle after lane 4; rx_done held high across the release.
  - Response: all outputs 0; no spurious lane_we; next word starts at lane 0.
